// File: rtl/br_amba_iso_us_fsm_mc.sv
// Multi-channel upstream AXI isolation controller: one Moore FSM sequences align/hold and request trackers.
// Optional align-phase timeout enabled by defining BR_AMBA_ISO_ALIGN_TIMEOUT_EN.
module br_amba_iso_us_fsm_mc #(
    parameter int NumChannels        = 2,
    parameter int MinFlushCycles     = 4,
    parameter int AlignTimeoutCycles = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   isolate_req,
    output logic                   isolate_done,
    output logic [NumChannels-1:0] align_and_hold_req,
    input  logic [NumChannels-1:0] align_and_hold_done,
    output logic [NumChannels-1:0] req_tracker_isolate_req,
    input  logic [NumChannels-1:0] req_tracker_isolate_done,
    output logic                   align_timeout
);

    if (NumChannels < 1) begin : g_bad_num_channels
        $error("NumChannels must be >= 1");
    end
    if (MinFlushCycles < 1) begin : g_bad_min_flush
        $error("MinFlushCycles must be >= 1");
    end
    if (AlignTimeoutCycles < 2) begin : g_bad_align_timeout
        $error("AlignTimeoutCycles must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_NORMAL      = 2'd0,
        ST_ALIGN_WRITE = 2'd1,
        ST_ISOLATE     = 2'd2,
        ST_FLUSH       = 2'd3
    } state_e;

    localparam int FlushCntW = $clog2(MinFlushCycles + 1);
    localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(MinFlushCycles - 1);
    localparam logic [FlushCntW-1:0] FlushMax  = FlushCntW'(MinFlushCycles);

    state_e               state;
    state_e               state_next;
    logic [FlushCntW-1:0] flush_cnt;
    logic                 all_align;
    logic                 all_trk;
    logic                 any_trk;
    logic                 flush_done;
    logic                 align_expired;

    assign all_align  = &align_and_hold_done;
    assign all_trk    = &req_tracker_isolate_done;
    assign any_trk    = |req_tracker_isolate_done;
    assign flush_done = (flush_cnt >= FlushLast);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Held at zero outside Flush, so the first Flush cycle always sees a count of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state != ST_FLUSH) begin
            flush_cnt <= '0;
        end else if (flush_cnt != FlushMax) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

`ifdef BR_AMBA_ISO_ALIGN_TIMEOUT_EN
    localparam int AlignCntW = $clog2(AlignTimeoutCycles + 1);
    localparam logic [AlignCntW-1:0] AlignLast = AlignCntW'(AlignTimeoutCycles - 1);

    logic [AlignCntW-1:0] align_cnt;
    logic                 align_timeout_q;

    assign align_expired = (align_cnt >= AlignLast);
    assign align_timeout = align_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_cnt <= '0;
        end else if (state != ST_ALIGN_WRITE) begin
            align_cnt <= '0;
        end else if (align_cnt != AlignLast) begin
            align_cnt <= align_cnt + 1'b1;
        end
    end

    // Sticky flag: set when AlignWrite is left by expiry alone, cleared on the next AlignWrite entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_timeout_q <= 1'b0;
        end else if (state == ST_NORMAL && state_next == ST_ALIGN_WRITE) begin
            align_timeout_q <= 1'b0;
        end else if (state == ST_ALIGN_WRITE && align_expired && !all_align) begin
            align_timeout_q <= 1'b1;
        end
    end
`else
    assign align_expired = 1'b0;
    assign align_timeout = 1'b0;
`endif

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_NORMAL: begin
                if (isolate_req) state_next = ST_ALIGN_WRITE;
            end
            ST_ALIGN_WRITE: begin
                // A dropped isolate_req does not abort alignment once it has started.
                if (all_align || align_expired) state_next = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                if (!isolate_req && all_trk) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!any_trk && flush_done) state_next = ST_NORMAL;
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    always_comb begin
        isolate_done            = 1'b0;
        align_and_hold_req      = '0;
        req_tracker_isolate_req = '0;
        case (state)
            ST_ALIGN_WRITE: begin
                align_and_hold_req = {NumChannels{1'b1}};
            end
            ST_ISOLATE: begin
                isolate_done            = 1'b1;
                align_and_hold_req      = {NumChannels{1'b1}};
                req_tracker_isolate_req = {NumChannels{1'b1}};
            end
            ST_FLUSH: begin
                isolate_done       = 1'b1;
                align_and_hold_req = {NumChannels{1'b1}};
            end
            default: ;
        endcase
    end

    a_state_known : assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(state));

    a_done_implies_align : assert property (@(posedge clk) disable iff (!rst_n)
        isolate_done |-> (&align_and_hold_req));

    a_trk_only_in_isolate : assert property (@(posedge clk) disable iff (!rst_n)
        (|req_tracker_isolate_req) |-> (state == ST_ISOLATE));

endmodule

// File: tb/tb_br_amba_iso_us_fsm_mc.sv
// Self-checking bench for br_amba_iso_us_fsm_mc: vector table plus hand-written multi-cycle sequences.
// Observed word is {isolate_done, align_and_hold_req[1:0], req_tracker_isolate_req[1:0], align_timeout}.
module tb_br_amba_iso_us_fsm_mc;

    localparam int NumChannels        = 2;
    localparam int MinFlushCycles     = 4;
    localparam int AlignTimeoutCycles = 8;

    localparam logic [5:0] NRM = 6'b0_00_00_0;
    localparam logic [5:0] AW  = 6'b0_11_00_0;
    localparam logic [5:0] ISO = 6'b1_11_11_0;
    localparam logic [5:0] FL  = 6'b1_11_00_0;
    localparam logic [5:0] TMO = 6'b0_00_00_1;

    typedef struct {
        logic       req;
        logic [1:0] ad;
        logic [1:0] td;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic                   isolate_req;
    logic                   isolate_done;
    logic [NumChannels-1:0] align_and_hold_req;
    logic [NumChannels-1:0] align_and_hold_done;
    logic [NumChannels-1:0] req_tracker_isolate_req;
    logic [NumChannels-1:0] req_tracker_isolate_done;
    logic                   align_timeout;
    logic [5:0]             obs;

    int         tests_run;
    int         tests_failed;
    logic [5:0] exp_q[$];
    vec_t       tbl[$];

    br_amba_iso_us_fsm_mc #(
        .NumChannels       (NumChannels),
        .MinFlushCycles    (MinFlushCycles),
        .AlignTimeoutCycles(AlignTimeoutCycles)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .isolate_req             (isolate_req),
        .isolate_done            (isolate_done),
        .align_and_hold_req      (align_and_hold_req),
        .align_and_hold_done     (align_and_hold_done),
        .req_tracker_isolate_req (req_tracker_isolate_req),
        .req_tracker_isolate_done(req_tracker_isolate_done),
        .align_timeout           (align_timeout)
    );

    assign obs = {isolate_done, align_and_hold_req, req_tracker_isolate_req, align_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
    task automatic step(input logic req, input logic [1:0] ad, input logic [1:0] td,
                        input logic [5:0] exp, input string name);
        isolate_req              = req;
        align_and_hold_done      = ad;
        req_tracker_isolate_done = td;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, " (scoreboard empty)"}, obs, ~exp);
        end else begin
            check(name, obs, exp_q.pop_front());
        end
    endtask

    task automatic add(input logic req, input logic [1:0] ad, input logic [1:0] td,
                       input logic [5:0] exp, input string name);
        vec_t v;
        v.req  = req;
        v.ad   = ad;
        v.td   = td;
        v.exp  = exp;
        v.name = name;
        tbl.push_back(v);
    endtask

    // From Isolate with isolate_req low: enter Flush, dwell the minimum, return to Normal.
    task automatic drain(input logic [5:0] tmo, input string tag);
        step(1'b0, 2'b11, 2'b11, FL | tmo, {tag, " flush entry"});
        for (int i = 0; i < MinFlushCycles - 1; i++) begin
            step(1'b0, 2'b11, 2'b00, FL | tmo, $sformatf("%s flush dwell %0d", tag, i));
        end
        step(1'b0, 2'b00, 2'b00, NRM | tmo, {tag, " back to normal"});
    endtask

    initial begin
        tests_run                = 0;
        tests_failed             = 0;
        rst_n                    = 1'b0;
        isolate_req              = 1'b0;
        align_and_hold_done      = '0;
        req_tracker_isolate_done = '0;

        // Main isolate/flush sequence, then a one-cycle request pulse with a re-request during Flush.
        add(1, 2'b00, 2'b00, AW,  "A align entry");
        add(1, 2'b00, 2'b00, AW,  "A align wait");
        add(1, 2'b01, 2'b00, AW,  "A partial align 01");
        add(1, 2'b01, 2'b00, AW,  "A partial align hold");
        add(1, 2'b11, 2'b00, ISO, "A all aligned -> isolate");
        add(1, 2'b11, 2'b01, ISO, "A isolate partial trk");
        add(1, 2'b11, 2'b11, ISO, "A isolate held by req");
        add(0, 2'b11, 2'b01, ISO, "A isolate waits all trk");
        add(0, 2'b11, 2'b11, FL,  "A flush entry");
        add(0, 2'b11, 2'b00, FL,  "A flush cnt1");
        add(0, 2'b11, 2'b00, FL,  "A flush cnt2");
        add(0, 2'b11, 2'b00, FL,  "A flush cnt3");
        add(0, 2'b00, 2'b00, NRM, "A back to normal");
        add(0, 2'b00, 2'b00, NRM, "A normal idle");
        add(1, 2'b00, 2'b00, AW,  "B pulse -> align");
        add(0, 2'b00, 2'b00, AW,  "B align req dropped");
        add(0, 2'b00, 2'b00, AW,  "B align still waits");
        add(0, 2'b11, 2'b11, ISO, "B late align -> isolate");
        add(0, 2'b11, 2'b11, FL,  "B trk done -> flush");
        add(1, 2'b11, 2'b01, FL,  "B flush req reasserted");
        add(1, 2'b11, 2'b01, FL,  "B flush cnt2");
        add(1, 2'b11, 2'b01, FL,  "B flush cnt3");
        add(1, 2'b11, 2'b01, FL,  "B flush trk busy past min");
        add(1, 2'b11, 2'b00, NRM, "B trk idle -> normal");
        add(1, 2'b00, 2'b00, AW,  "B normal held one cycle");
        add(0, 2'b11, 2'b00, ISO, "B realign -> isolate");

        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", obs, NRM);
        rst_n = 1'b1;
        step(1'b0, 2'b11, 2'b11, NRM, "normal ignores done inputs");

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].ad, tbl[i].td, tbl[i].exp, $sformatf("vec%0d %s", i, tbl[i].name));
        end
        drain(6'b0, "B");

`ifdef BR_AMBA_ISO_ALIGN_TIMEOUT_EN
        step(1'b1, 2'b10, 2'b00, AW, "T align entry");
        for (int i = 0; i < AlignTimeoutCycles - 1; i++) begin
            step(1'b1, 2'b10, 2'b00, AW, $sformatf("T align wait %0d", i));
        end
        step(1'b1, 2'b10, 2'b00, ISO | TMO, "T timeout -> isolate");
        step(1'b0, 2'b10, 2'b01, ISO | TMO, "T isolate sticky flag");
        drain(TMO, "T");
        step(1'b1, 2'b10, 2'b00, AW, "T2 entry clears flag");
        for (int i = 0; i < AlignTimeoutCycles - 1; i++) begin
            step(1'b1, 2'b10, 2'b00, AW, $sformatf("T2 align wait %0d", i));
        end
        step(1'b0, 2'b11, 2'b00, ISO, "T2 align on last cycle no flag");
        drain(6'b0, "T2");
`else
        step(1'b1, 2'b10, 2'b00, AW, "U align entry");
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 2'b10, 2'b00, AW, $sformatf("U align no timeout %0d", i));
        end
        step(1'b0, 2'b11, 2'b00, ISO, "U align done -> isolate");
        drain(6'b0, "U");
`endif

        // Asynchronous reset while isolated returns outputs to zero without a clock edge.
        step(1'b1, 2'b11, 2'b00, AW,  "R align entry");
        step(1'b1, 2'b11, 2'b00, ISO, "R isolate");
        #2;
        rst_n = 1'b0;
        #1;
        check("R async reset outputs", obs, NRM);
        @(posedge clk);
        #1;
        check("R held in reset", obs, NRM);
        rst_n = 1'b1;
        step(1'b0, 2'b11, 2'b11, NRM, "R normal after release");
        step(1'b1, 2'b00, 2'b00, AW,  "R restart align");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
